// File: rtl/imem_loader.sv
// Boot loader: parses a byte stream (length, N words, checksum) into instruction memory, then releases the CPU.
// Latency: each memory write is issued one cycle after its data-byte transfer; cpu_run rises one cycle after the checksum transfer.
// Backpressure: in_ready is a pure function of state (high in LEN/DATA/CSUM); offered bytes in other states are neither consumed nor written.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   in_data/in_valid/in_ready  stream byte handshake
//   restart                    reload request, honoured only in DONE or ERR
//   imem_we/imem_addr/imem_wdata  sequential instruction-memory write port
//   busy, cpu_run, load_err    status: loading, image good, image bad
module imem_loader #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,   // must be >= ADDR_W: the length field is taken from in_data
  parameter int CHECK_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              busy,
  output logic              cpu_run,
  output logic              load_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] last_idx;  // index of the final word; length 0 gives all-ones (2^ADDR_W words)
  logic [DATA_W-1:0] sum;
  logic              xfer;

  assign in_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign busy     = in_ready;
  assign cpu_run  = (state == S_DONE);
  assign load_err = (state == S_ERR);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      count      <= '0;
      last_idx   <= '0;
      sum        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      // Write strobe is a single-cycle pulse; address/data hold between writes.
      imem_we <= 1'b0;
      case (state)
        S_IDLE: state <= S_LEN;
        S_LEN: begin
          if (xfer) begin
            last_idx <= in_data[ADDR_W-1:0] - ONE_A;
            count    <= '0;
            sum      <= '0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            imem_we    <= 1'b1;
            imem_addr  <= count;
            imem_wdata <= in_data;
            count      <= count + ONE_A;  // wraps to 0 after a full-size image
            sum        <= sum + in_data;
            if (count == last_idx) state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (xfer) begin
            if ((CHECK_EN == 0) || (in_data == sum)) state <= S_DONE;
            else                                     state <= S_ERR;
          end
        end
        S_DONE, S_ERR: begin
          if (restart) state <= S_LEN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       restart = 1'b0;
  logic       in_ready, imem_we, busy, cpu_run, load_err;
  logic [7:0] imem_addr, imem_wdata;

  logic [7:0] nc_data = 8'h00;
  logic       nc_valid = 1'b0;
  logic       nc_restart = 1'b0;
  logic       nc_ready, nc_we, nc_busy, nc_run, nc_err;
  logic [7:0] nc_addr, nc_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8), .DATA_W(8), .CHECK_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .restart(restart), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .cpu_run(cpu_run), .load_err(load_err)
  );

  imem_loader #(.ADDR_W(8), .DATA_W(8), .CHECK_EN(0)) u_nc (
    .clk(clk), .rst_n(rst_n), .in_data(nc_data), .in_valid(nc_valid), .in_ready(nc_ready),
    .restart(nc_restart), .imem_we(nc_we), .imem_addr(nc_addr), .imem_wdata(nc_wdata),
    .busy(nc_busy), .cpu_run(nc_run), .load_err(nc_err)
  );

  // Memory-side write log, sampled mid-cycle.
  logic [15:0] wlog[$];
  always @(negedge clk) if (imem_we) wlog.push_back({imem_addr, imem_wdata});

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rs;
    logic       rdy;
    logic       we;
    logic [7:0] a;
    logic [7:0] wd;
    logic       bsy;
    logic       run;
    logic       err;
  } vec_t;

  function automatic vec_t mk(logic v, logic [7:0] d, logic rs, logic rdy, logic we,
                              logic [7:0] a, logic [7:0] wd, logic bsy, logic run, logic err);
    vec_t r;
    r.v = v; r.d = d; r.rs = rs; r.rdy = rdy; r.we = we;
    r.a = a; r.wd = wd; r.bsy = bsy; r.run = run; r.err = err;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[27];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Each row: inputs driven this cycle | outputs expected at the start of this cycle.
    //              v  d      rs    rdy we a      wd     bsy run err
    tbl[0]  = mk(0, 8'h00, 0,   0, 0, 8'h00, 8'h00, 0, 0, 0); // IDLE
    tbl[1]  = mk(1, 8'h03, 0,   1, 0, 8'h00, 8'h00, 1, 0, 0); // LEN
    tbl[2]  = mk(1, 8'h12, 0,   1, 0, 8'h00, 8'h00, 1, 0, 0);
    tbl[3]  = mk(1, 8'h34, 0,   1, 1, 8'h00, 8'h12, 1, 0, 0);
    tbl[4]  = mk(1, 8'h56, 0,   1, 1, 8'h01, 8'h34, 1, 0, 0);
    tbl[5]  = mk(1, 8'h9C, 0,   1, 1, 8'h02, 8'h56, 1, 0, 0); // CSUM, good
    tbl[6]  = mk(1, 8'h77, 0,   0, 0, 8'h02, 8'h56, 0, 1, 0); // DONE, byte not consumed
    tbl[7]  = mk(0, 8'h00, 1,   0, 0, 8'h02, 8'h56, 0, 1, 0); // restart
    tbl[8]  = mk(1, 8'h03, 0,   1, 0, 8'h02, 8'h56, 1, 0, 0); // LEN
    tbl[9]  = mk(1, 8'h12, 1,   1, 0, 8'h02, 8'h56, 1, 0, 0); // restart ignored in DATA
    tbl[10] = mk(1, 8'h34, 0,   1, 1, 8'h00, 8'h12, 1, 0, 0);
    tbl[11] = mk(1, 8'h56, 0,   1, 1, 8'h01, 8'h34, 1, 0, 0);
    tbl[12] = mk(1, 8'h9D, 0,   1, 1, 8'h02, 8'h56, 1, 0, 0); // bad checksum
    tbl[13] = mk(0, 8'h00, 0,   0, 0, 8'h02, 8'h56, 0, 0, 1); // ERR
    tbl[14] = mk(0, 8'h00, 1,   0, 0, 8'h02, 8'h56, 0, 0, 1); // restart
    tbl[15] = mk(1, 8'h01, 0,   1, 0, 8'h02, 8'h56, 1, 0, 0);
    tbl[16] = mk(1, 8'hAA, 1,   1, 0, 8'h02, 8'h56, 1, 0, 0);
    tbl[17] = mk(1, 8'hAA, 0,   1, 1, 8'h00, 8'hAA, 1, 0, 0);
    tbl[18] = mk(0, 8'h00, 1,   0, 0, 8'h00, 8'hAA, 0, 1, 0); // DONE, restart
    tbl[19] = mk(1, 8'h02, 0,   1, 0, 8'h00, 8'hAA, 1, 0, 0); // toggling valid
    tbl[20] = mk(0, 8'h0F, 0,   1, 0, 8'h00, 8'hAA, 1, 0, 0);
    tbl[21] = mk(1, 8'h0F, 0,   1, 0, 8'h00, 8'hAA, 1, 0, 0);
    tbl[22] = mk(0, 8'hF1, 0,   1, 1, 8'h00, 8'h0F, 1, 0, 0);
    tbl[23] = mk(1, 8'hF1, 0,   1, 0, 8'h00, 8'h0F, 1, 0, 0);
    tbl[24] = mk(0, 8'h00, 0,   1, 1, 8'h01, 8'hF1, 1, 0, 0);
    tbl[25] = mk(1, 8'h00, 0,   1, 0, 8'h01, 8'hF1, 1, 0, 0); // 0F+F1 = 00
    tbl[26] = mk(0, 8'h00, 0,   0, 0, 8'h01, 8'hF1, 0, 1, 0);

    // Reset
    #2 rst_n = 1'b0;
    #1;
    chk("rst.in_ready", in_ready, 0);
    chk("rst.imem_we", imem_we, 0);
    chk("rst.imem_addr", imem_addr, 0);
    chk("rst.imem_wdata", imem_wdata, 0);
    chk("rst.busy", busy, 0);
    chk("rst.cpu_run", cpu_run, 0);
    chk("rst.load_err", load_err, 0);
    step();
    step();
    rst_n = 1'b1;
    wlog.delete();

    // Table-driven streams: good load, bad checksum + reload, toggled valid with wrapping sum
    for (int i = 0; i < 27; i++) begin
      chk($sformatf("vec%0d.in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("vec%0d.imem_we", i), imem_we, tbl[i].we);
      chk($sformatf("vec%0d.imem_addr", i), imem_addr, tbl[i].a);
      chk($sformatf("vec%0d.imem_wdata", i), imem_wdata, tbl[i].wd);
      chk($sformatf("vec%0d.busy", i), busy, tbl[i].bsy);
      chk($sformatf("vec%0d.cpu_run", i), cpu_run, tbl[i].run);
      chk($sformatf("vec%0d.load_err", i), load_err, tbl[i].err);
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      restart  = tbl[i].rs;
      step();
    end
    chk("tbl.write_count", wlog.size(), 9);

    // Full-size image: length 0 means 256 words, data k at address k, checksum 80
    restart = 1'b1; in_valid = 1'b0;
    step();
    restart = 1'b0;
    wlog.delete();
    in_valid = 1'b1; in_data = 8'h00;
    step();
    for (int k = 0; k < 256; k++) begin
      in_data = 8'(k);
      step();
    end
    chk("len0.in_ready_csum", in_ready, 1);
    in_data = 8'h80;
    step();
    in_valid = 1'b0;
    chk("len0.cpu_run", cpu_run, 1);
    chk("len0.load_err", load_err, 0);
    chk("len0.write_count", wlog.size(), 256);
    begin
      int bad = 0;
      for (int k = 0; k < wlog.size(); k++)
        if (wlog[k] !== {8'(k), 8'(k)}) bad++;
      chk("len0.write_contents_bad", bad, 0);
    end
    if (wlog.size() == 256) chk("len0.last_write", wlog[255], 16'hFFFF);

    // Reset in the middle of a 5-word load
    restart = 1'b1;
    step();
    restart = 1'b0;
    in_valid = 1'b1; in_data = 8'h05;
    step();
    in_data = 8'h01;
    step();
    in_data = 8'h02;
    step();
    in_valid = 1'b0;
    chk("midrst.we_before", imem_we, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst.imem_we", imem_we, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.cpu_run", cpu_run, 0);
    chk("midrst.in_ready", in_ready, 0);
    chk("midrst.imem_addr", imem_addr, 0);
    step();
    rst_n = 1'b1;
    chk("midrst.idle_ready", in_ready, 0);
    step();
    chk("midrst.len_ready", in_ready, 1);
    chk("midrst.len_busy", busy, 1);

    // Fresh length byte after reset; CHECK_EN=0 instance runs in parallel
    in_valid = 1'b1; in_data = 8'h01;
    nc_valid = 1'b1; nc_data = 8'h01;
    step();
    in_data = 8'h42;
    nc_data = 8'h55; nc_restart = 1'b1;
    step();
    nc_restart = 1'b0;
    chk("post.imem_we", imem_we, 1);
    chk("post.imem_addr", imem_addr, 0);
    chk("post.imem_wdata", imem_wdata, 8'h42);
    chk("nc.imem_we", nc_we, 1);
    chk("nc.imem_addr", nc_addr, 0);
    chk("nc.imem_wdata", nc_wdata, 8'h55);
    chk("nc.busy_after_restart", nc_busy, 1);
    in_data = 8'h42;
    nc_data = 8'h00;
    step();
    in_valid = 1'b0;
    nc_valid = 1'b0;
    chk("post.cpu_run", cpu_run, 1);
    chk("post.load_err", load_err, 0);
    chk("nc.cpu_run", nc_run, 1);
    chk("nc.load_err", nc_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
